// File: rtl/rt_bypass_pkg.sv
// Shared types, source-select codes and code helpers for the rt operand-bypass unit.
package rt_bypass_pkg;

    // Widest register address a tag can hold; narrower REG_AW values are zero-extended.
    localparam int TAG_AW = 8;

    localparam int SEL_RF  = 0;
    localparam int SEL_IMM = 1;

    typedef struct packed {
        logic              v;
        logic [TAG_AW-1:0] rd;
        logic              load;
    } tag_t;

    // Select code for in-flight stage k (k = 1..STAGES-1).
    function automatic int sel_fwd(input int k);
        return k + 1;
    endfunction

    // Select code for the retire buffer.
    function automatic int sel_ret(input int stages);
        return stages + 1;
    endfunction

endpackage

// File: rtl/rt_bypass_sel.sv
// Per-operand source select: immediate, youngest in-flight producer, retire buffer or
// register file, plus the load-use hit for this operand.
module rt_bypass_sel
    import rt_bypass_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5,
    parameter int SEL_W    = 3
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              use_imm,
    input  tag_t              tags [STAGES],
    input  logic              ret_v,
    input  logic [TAG_AW-1:0] ret_rd,
    output logic [SEL_W-1:0]  sel,
    output logic              load_hit
);

    logic [TAG_AW-1:0] rs_ext;
    assign rs_ext = TAG_AW'(rs);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        sel      = SEL_W'(SEL_RF);
        load_hit = 1'b0;
        if (use_imm) begin
            sel = SEL_W'(SEL_IMM);
        end else if (rs != '0) begin
            if (ret_v && ret_rd == rs_ext)
                sel = SEL_W'(sel_ret(STAGES));
            // Walk oldest to youngest so the youngest matching producer overwrites.
            for (int j = STAGES - 1; j >= 0; j--) begin
                if (tags[j].v && tags[j].rd == rs_ext)
                    sel = (j == STAGES - 1) ? SEL_W'(sel_ret(STAGES)) : SEL_W'(sel_fwd(j + 1));
            end
            for (int j = 0; j < STAGES; j++) begin
                if (j < LOAD_LAT && tags[j].v && tags[j].load && tags[j].rd == rs_ext)
                    load_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rt_bypass_unit.sv
// ID/EX operand-bypass unit with in-flight tag tracking and load-use stall request.
// Optional counters enabled by defining RT_BYPASS_STATS_EN.
module rt_bypass_unit
    import rt_bypass_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  REG_AW   = 5,
    parameter int  NUM_OPS  = 2,
    parameter int  STAGES   = 3,
    parameter int  LOAD_LAT = 1,
    localparam int SEL_W    = $clog2(STAGES + 2)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         freeze_i,
    input  logic                         hold_i,
    input  logic                         flush_i,
    input  logic                         id_valid_i,
    input  logic [NUM_OPS*REG_AW-1:0]    id_rs_i,
    input  logic [NUM_OPS-1:0]           id_use_imm_i,
    input  logic                         id_wr_en_i,
    input  logic [REG_AW-1:0]            id_rd_i,
    input  logic                         id_is_load_i,
    input  logic [NUM_OPS*DATA_W-1:0]    rf_data_i,
    input  logic [DATA_W-1:0]            imm_i,
    input  logic [(STAGES-1)*DATA_W-1:0] stage_data_i,
    output logic [NUM_OPS*DATA_W-1:0]    src_o,
    output logic [NUM_OPS*SEL_W-1:0]     sel_o,
    output logic                         stall_req_o
`ifdef RT_BYPASS_STATS_EN
    ,
    output logic [31:0]                  fwd_cnt_o,
    output logic [31:0]                  stall_cnt_o
`endif
);

    tag_t               tags_q [STAGES];
    logic               ret_v_q;
    logic [TAG_AW-1:0]  ret_rd_q;
    logic [DATA_W-1:0]  ret_data_q;
    logic [SEL_W-1:0]   sel_d [NUM_OPS];
    logic [SEL_W-1:0]   sel_q [NUM_OPS];
    logic [NUM_OPS-1:0] load_hit;
    logic [NUM_OPS*DATA_W-1:0] rf_q;
    logic [DATA_W-1:0]  imm_q;
    logic               bubble;

    assign bubble = hold_i | flush_i;

    // NOTE: the tag pipe is control state and must be reset so no pre-reset producer forwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) tags_q[k] <= '0;
            ret_v_q    <= 1'b0;
            ret_rd_q   <= '0;
            ret_data_q <= '0;
        end else if (!freeze_i) begin
            tags_q[0] <= '{v:    id_valid_i & id_wr_en_i & ~bubble,
                           rd:   TAG_AW'(id_rd_i),
                           load: id_is_load_i};
            for (int k = 1; k < STAGES; k++) tags_q[k] <= tags_q[k-1];
            ret_v_q    <= tags_q[STAGES-1].v;
            ret_rd_q   <= tags_q[STAGES-1].rd;
            ret_data_q <= stage_data_i[(STAGES-1)*DATA_W-1 -: DATA_W];
        end
    end

    for (genvar op = 0; op < NUM_OPS; op++) begin : g_op
        rt_bypass_sel #(
            .STAGES  (STAGES),
            .LOAD_LAT(LOAD_LAT),
            .REG_AW  (REG_AW),
            .SEL_W   (SEL_W)
        ) u_sel (
            .rs      (id_rs_i[op*REG_AW +: REG_AW]),
            .use_imm (id_use_imm_i[op]),
            .tags    (tags_q),
            .ret_v   (ret_v_q),
            .ret_rd  (ret_rd_q),
            .sel     (sel_d[op]),
            .load_hit(load_hit[op])
        );
    end

    assign stall_req_o = id_valid_i & (|load_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int op = 0; op < NUM_OPS; op++) sel_q[op] <= SEL_W'(SEL_RF);
            rf_q  <= '0;
            imm_q <= '0;
        end else if (!freeze_i) begin
            imm_q <= imm_i;
            rf_q  <= bubble ? '0 : rf_data_i;
            for (int op = 0; op < NUM_OPS; op++)
                sel_q[op] <= bubble ? SEL_W'(SEL_RF) : sel_d[op];
        end
    end

    always_comb begin
        src_o = '0;
        sel_o = '0;
        for (int op = 0; op < NUM_OPS; op++) begin
            sel_o[op*SEL_W +: SEL_W] = sel_q[op];
            if (sel_q[op] == SEL_W'(SEL_RF))
                src_o[op*DATA_W +: DATA_W] = rf_q[op*DATA_W +: DATA_W];
            else if (sel_q[op] == SEL_W'(SEL_IMM))
                src_o[op*DATA_W +: DATA_W] = imm_q;
            else if (sel_q[op] == SEL_W'(sel_ret(STAGES)))
                src_o[op*DATA_W +: DATA_W] = ret_data_q;
            for (int k = 1; k < STAGES; k++) begin
                if (sel_q[op] == SEL_W'(sel_fwd(k)))
                    src_o[op*DATA_W +: DATA_W] = stage_data_i[(k-1)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RT_BYPASS_STATS_EN
    logic fwd_any;

    // Counted as the select enters EX, so bubbles never contribute.
    always_comb begin
        fwd_any = 1'b0;
        for (int op = 0; op < NUM_OPS; op++) begin
            if (sel_d[op] != SEL_W'(SEL_RF) && sel_d[op] != SEL_W'(SEL_IMM))
                fwd_any = 1'b1;
        end
        if (bubble) fwd_any = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else if (!freeze_i) begin
            if (fwd_any && fwd_cnt_o != 32'hFFFF_FFFF)       fwd_cnt_o   <= fwd_cnt_o + 32'd1;
            if (stall_req_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
